// File: rtl/cu_pkg.sv
// Shared types and constants for the ProjectB controller: state encoding,
// opcode values and ALU select codes.
package cu_pkg;

  localparam int unsigned IW  = 16;
  localparam int unsigned DAW = 8;
  localparam int unsigned RAW = 4;
  localparam int unsigned OPW = 4;
  localparam int unsigned ASW = 3;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } cu_state_t;

  localparam logic [OPW-1:0] OP_NOOP  = 4'd0;
  localparam logic [OPW-1:0] OP_STORE = 4'd1;
  localparam logic [OPW-1:0] OP_LOAD  = 4'd2;
  localparam logic [OPW-1:0] OP_ADD   = 4'd3;
  localparam logic [OPW-1:0] OP_SUB   = 4'd4;
  localparam logic [OPW-1:0] OP_HALT  = 4'd5;

  localparam logic [ASW-1:0] ALU_PASS = 3'd0;
  localparam logic [ASW-1:0] ALU_ADD  = 3'd1;
  localparam logic [ASW-1:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/control_unit.sv
// ProjectB controller FSM: Init/Fetch/Decode/Execute sequencing with Moore
// strobes decoded from state and IR fields. CU_MEM_WAIT_EN splits LOAD in two.
module control_unit
  import cu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [IW-1:0]  ir,
  output logic           pc_clr,
  output logic           pc_up,
  output logic           ir_ld,
  output logic [DAW-1:0] d_addr,
  output logic           d_wr,
  output logic           rf_s,
  output logic [RAW-1:0] rf_w_addr,
  output logic           rf_w_en,
  output logic [RAW-1:0] rf_ra_addr,
  output logic [RAW-1:0] rf_rb_addr,
  output logic [ASW-1:0] alu_s0,
  output logic           halted
);

  cu_state_t state, state_nxt;
  logic [OPW-1:0] opcode;

  assign opcode = ir[15:12];

  // State register; reset forces INIT even mid-instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_clr     = 1'b0;
    pc_up      = 1'b0;
    ir_ld      = 1'b0;
    d_addr     = '0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = '0;
    rf_w_en    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    alu_s0     = ALU_PASS;
    halted     = 1'b0;

    unique case (state)
      ST_INIT: begin
        pc_clr    = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        ir_ld     = 1'b1;
        pc_up     = 1'b1;
        state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        unique case (opcode)
          OP_STORE: state_nxt = ST_STORE;
          OP_LOAD:  state_nxt = ST_LOAD_A;
          OP_ADD:   state_nxt = ST_ADD;
          OP_SUB:   state_nxt = ST_SUB;
          OP_HALT:  state_nxt = ST_HALT;
          default:  state_nxt = ST_NOOP;
        endcase
      end
      ST_NOOP: state_nxt = ST_FETCH;
      ST_STORE: begin
        d_addr     = ir[7:0];
        rf_ra_addr = ir[11:8];
        alu_s0     = ALU_PASS;
        d_wr       = 1'b1;
        state_nxt  = ST_FETCH;
      end
`ifdef CU_MEM_WAIT_EN
      // Address phase only; synchronous-read memory returns data next cycle.
      ST_LOAD_A: begin
        d_addr    = ir[11:4];
        state_nxt = ST_LOAD_B;
      end
`else
      ST_LOAD_A: begin
        d_addr    = ir[11:4];
        rf_s      = 1'b1;
        rf_w_addr = ir[3:0];
        rf_w_en   = 1'b1;
        state_nxt = ST_FETCH;
      end
`endif
      ST_LOAD_B: begin
        d_addr    = ir[11:4];
        rf_s      = 1'b1;
        rf_w_addr = ir[3:0];
        rf_w_en   = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_ADD, ST_SUB: begin
        rf_ra_addr = ir[11:8];
        rf_rb_addr = ir[7:4];
        rf_w_addr  = ir[3:0];
        rf_s       = 1'b0;
        alu_s0     = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
        rf_w_en    = 1'b1;
        state_nxt  = ST_FETCH;
      end
      ST_HALT: begin
        halted    = 1'b1;
        state_nxt = ST_HALT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

endmodule
